// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, helpers and FSM states for the UART autobaud path
//
// Contents:
//   BAUD_*          2-bit baud codes, same encoding the baud rate generator consumes
//   DEFAULT_CLK_HZ  default system clock frequency
//   P_*             integer bit periods in clk cycles at DEFAULT_CLK_HZ
//   TH_*            classification thresholds (midpoints of adjacent periods)
//   state_e         autobaud detector FSM states
package uart_pkg;

  localparam logic [1:0] BAUD_4800  = 2'b00;
  localparam logic [1:0] BAUD_9600  = 2'b01;
  localparam logic [1:0] BAUD_14400 = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam int unsigned DEFAULT_CLK_HZ = 5_000_000;

  // Midpoint between the integer bit periods of two adjacent rates.
  function automatic int unsigned mid_period(input int unsigned clk_hz,
                                             input int unsigned rate_fast,
                                             input int unsigned rate_slow);
    return ((clk_hz / rate_fast) + (clk_hz / rate_slow)) / 2;
  endfunction

  localparam int unsigned P_4800  = DEFAULT_CLK_HZ / 4800;
  localparam int unsigned P_9600  = DEFAULT_CLK_HZ / 9600;
  localparam int unsigned P_14400 = DEFAULT_CLK_HZ / 14400;
  localparam int unsigned P_19200 = DEFAULT_CLK_HZ / 19200;

  // Largest width classified as each faster rate.
  localparam int unsigned TH_19200 = (P_19200 + P_14400) / 2;
  localparam int unsigned TH_14400 = (P_14400 + P_9600) / 2;
  localparam int unsigned TH_9600  = (P_9600 + P_4800) / 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_WAIT_FALL,
    ST_MEAS_LOW,
`ifdef AUTOBAUD_VERIFY_EN
    ST_VERIFY_HIGH,
`endif
    ST_DONE
  } state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the asynchronous rx line
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low; both flops reset to 1 (line idle)
//   d      raw asynchronous input
//   q      synchronized output, two clk cycles behind d
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_autobaud_detector.sv
// rtl/uart_autobaud_detector.sv - measures the start bit of a 0x55 sync character and emits a baud code
//
// Optional feature macro: AUTOBAUD_VERIFY_EN (cross-checks the following high bit before locking)
//
// Ports:
//   clk     system clock
//   reset   asynchronous, active-low reset
//   rx      raw serial line, asynchronous, idle high
//   start   single-cycle arm/re-arm request
//   baud    detected baud code (generator encoding)
//   locked  sticky, baud is valid; cleared by start or reset
//   err     sticky, detection failed; cleared by start or reset
//   busy    high in every state except IDLE and DONE
module uart_autobaud_detector
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ   = DEFAULT_CLK_HZ,
  parameter int unsigned MIN_CYC  = 200,
  parameter int unsigned MAX_CYC  = 1300,
  parameter int unsigned IDLE_CYC = 400,
  parameter int unsigned CW       = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       start,
  output logic [1:0] baud,
  output logic       locked,
  output logic       err,
  output logic       busy
);

  localparam logic [CW-1:0] MIN_L  = CW'(MIN_CYC);
  localparam logic [CW-1:0] MAX_L  = CW'(MAX_CYC);
  localparam logic [CW-1:0] IDLE_L = CW'(IDLE_CYC);
  localparam logic [CW-1:0] TH_11  = CW'(mid_period(CLK_HZ, 19200, 14400));
  localparam logic [CW-1:0] TH_10  = CW'(mid_period(CLK_HZ, 14400, 9600));
  localparam logic [CW-1:0] TH_01  = CW'(mid_period(CLK_HZ, 9600, 4800));

  logic rx_s;

  uart_rx_sync u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;      // idle-high run length, then H in verify mode
  logic [CW-1:0] len_q, len_d;      // measured low width L
  logic [1:0]    baud_q, baud_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;

  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] len_inc;
  logic [1:0]    baud_class;

  assign cnt_inc = cnt_q + CW'(1);
  // Saturates one past MAX so an over-long low can never wrap back into range.
  assign len_inc = (len_q > MAX_L) ? len_q : len_q + CW'(1);

  always_comb begin
    if (len_q <= TH_11) begin
      baud_class = BAUD_19200;
    end else if (len_q <= TH_10) begin
      baud_class = BAUD_14400;
    end else if (len_q <= TH_01) begin
      baud_class = BAUD_9600;
    end else begin
      baud_class = BAUD_4800;
    end
  end

`ifdef AUTOBAUD_VERIFY_EN
  logic [CW-1:0] hl_diff;
  assign hl_diff = (cnt_q >= len_q) ? (cnt_q - len_q) : (len_q - cnt_q);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    baud_d   = baud_q;
    locked_d = locked_q;
    err_d    = err_q;

    // start overrides whatever the FSM would do this cycle, including a lock.
    if (start) begin
      locked_d = 1'b0;
      err_d    = 1'b0;
      cnt_d    = '0;
      len_d    = '0;
      state_d  = ST_WAIT_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
        end
        ST_WAIT_IDLE: begin
          if (rx_s) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= IDLE_L) begin
              state_d = ST_WAIT_FALL;
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_WAIT_FALL: begin
          if (!rx_s) begin
            len_d   = CW'(1);
            state_d = ST_MEAS_LOW;
          end
        end
        ST_MEAS_LOW: begin
          if (!rx_s) begin
            len_d = len_inc;
            if (len_inc > MAX_L) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (len_q < MIN_L) begin
            state_d = ST_WAIT_FALL;
          end else begin
`ifdef AUTOBAUD_VERIFY_EN
            cnt_d   = CW'(1);
            state_d = ST_VERIFY_HIGH;
`else
            baud_d   = baud_class;
            locked_d = 1'b1;
            state_d  = ST_DONE;
`endif
          end
        end
`ifdef AUTOBAUD_VERIFY_EN
        ST_VERIFY_HIGH: begin
          if (rx_s) begin
            cnt_d = cnt_inc;
            if (cnt_inc > MAX_L) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (hl_diff <= (len_q >> 2)) begin
            baud_d   = baud_class;
            locked_d = 1'b1;
            state_d  = ST_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      baud_q   <= BAUD_9600;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      baud_q   <= baud_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign baud   = baud_q;
  assign locked = locked_q;
  assign err    = err_q;
  assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: doc/uart_autobaud_detector.md
Name: uart_autobaud_detector

Overview:
Receive-side counterpart of the baud rate generator. It watches the raw UART rx line and times the start bit of a 0x55 sync character in clk cycles, then classifies that width into the same 2-bit baud code the generator consumes (00=4800, 01=9600, 10=14400, 11=19200, at 5 MHz clk). It sits between the rx pin and the generator's baud input, so the link locks to the far end's rate without software.

Parameters:
CLK_HZ, 5000000, clk frequency; all bit periods derive from it
MIN_CYC, 200, low pulses shorter than this are glitches and are ignored
MAX_CYC, 1300, low pulses longer than this are break/error
IDLE_CYC, 400, rx must be high for this many cycles before a falling edge is accepted
CW, 12, counter width; must hold MAX_CYC+1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx  input  1  raw serial line, asynchronous to clk, idle high
start  input  1  single-cycle arm/re-arm request
baud  output  2  detected baud code, same encoding as the generator
locked  output  1  sticky high once baud is valid; cleared by start or reset
err  output  1  sticky high on failed detection; cleared by start or reset
busy  output  1  high in every state except IDLE and DONE

Behaviour:
- rx passes through a 2-flop synchronizer reset to 1, giving rx_s. All timing uses rx_s.
- Reset values: baud=2'b01, locked=0, err=0, busy=0, state=IDLE, counters=0. Asserting reset mid-measurement aborts it immediately.
- States: IDLE, WAIT_IDLE, WAIT_FALL, MEAS_LOW, [VERIFY_HIGH], DONE.
- start in any state: clear locked and err, clear the counter, go to WAIT_IDLE next cycle. baud keeps its old value.
- WAIT_IDLE: the counter counts consecutive rx_s=1 cycles and resets to 0 on rx_s=0. Reaching IDLE_CYC moves to WAIT_FALL.
- WAIT_FALL: on rx_s=0, load count L=1 and go to MEAS_LOW.
- MEAS_LOW: L increments each cycle rx_s=0 and saturates at MAX_CYC+1.
  - If L exceeds MAX_CYC: err=1, go to IDLE.
  - On rx_s=1 with L<MIN_CYC: treat as a glitch, go back to WAIT_FALL, no flags change.
  - On rx_s=1 with MIN_CYC<=L<=MAX_CYC: classify L.
- Classification thresholds are midpoints of integer periods 260/347/520/1041:
  - L<=303 gives 11
  - 304..433 gives 10
  - 434..780 gives 01
  - 781..MAX_CYC gives 00
- Without the verify feature: baud updates and locked=1 on the cycle after the first rx_s=1 cycle, then go to DONE. Raw-rx-rise to locked latency is 3 clk.
- DONE: hold outputs and ignore rx until start.
- start and the rx_s rising edge in the same cycle: start wins, no lock.

Optional Feature:
Macro AUTOBAUD_VERIFY_EN.
- Defined: after a valid L, enter VERIFY_HIGH and count the following high pulse H (bit0 of 0x55), starting at 1.
  - On the next rx_s=0, accept only if |H-L| <= L>>2. Then update baud, set locked=1, go to DONE.
  - Otherwise set err=1, go to IDLE.
  - H exceeding MAX_CYC also sets err=1 and goes to IDLE.
  - Lock latency becomes one cycle after the falling edge that ends H.
- Undefined: VERIFY_HIGH does not exist; lock happens at the end of L.

Decomposition:
- Package uart_pkg:
  - baud code constants (BAUD_4800=2'b00 ... BAUD_19200=2'b11), matching the generator's encoding
  - CLK_HZ default
  - period constants CLK_HZ/rate
  - the three classification thresholds
  - the FSM state enum
- One sub-module: uart_rx_sync, a 2-flop synchronizer with active-low asynchronous reset to 1. The generator's rx path reuses it.

Test Plan:
- Reset, start, 500 high, 521 low, then high: baud=01 and locked=1 exactly 3 clk after raw rise; busy=0.
- start, 500 high, low of 1042 / 347 / 261: baud=00 / 10 / 11 respectively; boundary lows of 303 and 304 give 11 and 10.
- start, 500 high, 100-cycle low glitch, 300 high, 520 low: glitch ignored, baud=01, err=0.
- start, 500 high, 1500 low: err=1 at cycle 1301 of the low, locked=0, baud keeps its previous value; a following start clears err.
- Reset asserted at low cycle 300: all outputs at reset values at once; after release with no start, state stays IDLE and rx edges are ignored.
- With AUTOBAUD_VERIFY_EN: L=347, H=520 gives err=1; L=347, H=360 gives baud=10 and locked=1. Without the macro: L=347 locks 10 regardless of H.
